// File: rtl/mac_pkg.sv
// Shared types and sizing helpers for the MAC-array vector sequencer.
package mac_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_WAIT   = 2'd2
    } state_e;

    // WAIT cycles allowed before giving up on mac_valid (timeout build only)
    localparam int TIMEOUT = 64;

    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

    // Accumulator width produced by the MAC array for N products of WIDTH x WIDTH
    function automatic int m_width(input int n, input int w);
        return 2 * w + n - 1;
    endfunction

endpackage

// File: rtl/mac_operand_bank.sv
// A (N x N) and B (N) operand registers with a single write port and a
// combinational read of column k of A plus B[k].
module mac_operand_bank
    import mac_pkg::*;
#(
    parameter int N     = 5,
    parameter int WIDTH = 16,
    parameter int IDX_W = clog2_min1(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we_i,
    input  logic               sel_i,
    input  logic [IDX_W-1:0]   row_i,
    input  logic [IDX_W-1:0]   col_i,
    input  logic [WIDTH-1:0]   data_i,
    input  logic [IDX_W-1:0]   rd_k_i,
    output logic [N*WIDTH-1:0] col_a_o,
    output logic [WIDTH-1:0]   col_b_o
);

    localparam logic [IDX_W:0] N_L = (IDX_W + 1)'(N);

    logic [WIDTH-1:0] a_q [N][N];
    logic [WIDTH-1:0] b_q [N];

    logic row_ok, col_ok;
    assign row_ok = ({1'b0, row_i} < N_L);
    assign col_ok = ({1'b0, col_i} < N_L);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                b_q[i] <= '0;
                for (int j = 0; j < N; j++) a_q[i][j] <= '0;
            end
        end else if (we_i && col_ok) begin
            // B writes ignore the row index entirely
            if (sel_i) begin
                b_q[col_i] <= data_i;
            end else if (row_ok) begin
                a_q[row_i][col_i] <= data_i;
            end
        end
    end

    always_comb begin
        col_a_o = '0;
        for (int i = 0; i < N; i++) col_a_o[i*WIDTH +: WIDTH] = a_q[i][rd_k_i];
        col_b_o = b_q[rd_k_i];
    end

endmodule

// File: rtl/mac_vec_sequencer.sv
// Streams A columns / B elements into the MAC array, then captures the N lane results.
// Optional build macro MAC_VEC_SEQ_TIMEOUT_EN adds a sticky WAIT timeout flag on err.
module mac_vec_sequencer
    import mac_pkg::*;
#(
    parameter int N       = 5,
    parameter int WIDTH   = 16,
    parameter int M_WIDTH = m_width(N, WIDTH),
    parameter int IDX_W   = clog2_min1(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic                 wr_sel,
    input  logic [IDX_W-1:0]     wr_row,
    input  logic [IDX_W-1:0]     wr_col,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 mac_sof,
    output logic [N*WIDTH-1:0]   mac_A,
    output logic [WIDTH-1:0]     mac_B,
    input  logic [N*M_WIDTH-1:0] mac_C,
    input  logic [N-1:0]         mac_valid,
    output logic [N*M_WIDTH-1:0] res_data,
    output logic                 err,
    output state_e               dbg_state
);

    localparam logic [IDX_W-1:0] K_LAST = IDX_W'(N - 1);

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     k_q, k_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 sof_q, sof_d;
    logic [N*WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [N*M_WIDTH-1:0] res_q, res_d;

    logic [N*WIDTH-1:0]   col_a;
    logic [WIDTH-1:0]     col_b;

`ifdef MAC_VEC_SEQ_TIMEOUT_EN
    localparam int CNT_W = clog2_min1(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    // Operands are frozen while a frame is in flight
    mac_operand_bank #(
        .N     (N),
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (wr_en & ~busy_q),
        .sel_i   (wr_sel),
        .row_i   (wr_row),
        .col_i   (wr_col),
        .data_i  (wr_data),
        .rd_k_i  (k_q),
        .col_a_o (col_a),
        .col_b_o (col_b)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sof_d   = 1'b0;
        a_d     = '0;
        b_d     = '0;
        res_d   = res_q;
`ifdef MAC_VEC_SEQ_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_STREAM;
                    k_d     = '0;
                    busy_d  = 1'b1;
                end
            end
            S_STREAM: begin
                sof_d = (k_q == '0);
                a_d   = col_a;
                b_d   = col_b;
                k_d   = k_q + 1'b1;
                if (k_q == K_LAST) begin
                    state_d = S_WAIT;
                    k_d     = '0;
`ifdef MAC_VEC_SEQ_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_WAIT: begin
                // Only a complete set of lane valids counts as a result
                if (&mac_valid) begin
                    res_d   = mac_C;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
`ifdef MAC_VEC_SEQ_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sof_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sof_q   <= sof_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

`ifdef MAC_VEC_SEQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign busy      = busy_q;
    assign done      = done_q;
    assign mac_sof   = sof_q;
    assign mac_A     = a_q;
    assign mac_B     = b_q;
    assign res_data  = res_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mac_vec_sequencer.sv
// Self-checking bench: behavioural MAC array + matrix-vector reference model.
module tb_mac_vec_sequencer;
    import mac_pkg::*;

    localparam int N       = 5;
    localparam int WIDTH   = 16;
    localparam int M_WIDTH = 2 * WIDTH + N - 1;
    localparam int IDX_W   = 3;

    // clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                 wr_en   = 1'b0;
    logic                 wr_sel  = 1'b0;
    logic [IDX_W-1:0]     wr_row  = '0;
    logic [IDX_W-1:0]     wr_col  = '0;
    logic [WIDTH-1:0]     wr_data = '0;
    logic                 start   = 1'b0;
    logic                 busy, done, mac_sof, err;
    logic [N*WIDTH-1:0]   mac_A;
    logic [WIDTH-1:0]     mac_B;
    logic [N*M_WIDTH-1:0] mac_C;
    logic [N-1:0]         mac_valid;
    logic [N*M_WIDTH-1:0] res_data;
    state_e               dbg_state;

    mac_vec_sequencer #(
        .N(N), .WIDTH(WIDTH), .M_WIDTH(M_WIDTH), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data), .start(start),
        .busy(busy), .done(done), .mac_sof(mac_sof), .mac_A(mac_A),
        .mac_B(mac_B), .mac_C(mac_C), .mac_valid(mac_valid),
        .res_data(res_data), .err(err), .dbg_state(dbg_state)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [WIDTH-1:0]     ref_a [N][N];
    logic [WIDTH-1:0]     ref_b [N];
    logic [N*M_WIDTH-1:0] exp_q [$];
    logic                 exp_err = 1'b0;

    // behavioural MAC array: per-lane accumulate, each lane valid after a random delay
    longint     acc [N];
    int         delay [N];
    int         mdl_cnt = 0;
    int         since = 0;
    int         mdl_maxd = 0;
    logic [N-1:0] mdl_valid = '0;
    logic       force_invalid = 1'b0;

    always @(negedge clk) begin
        logic signed [WIDTH-1:0] sa, sb;
        if (!rst_n) begin
            mdl_valid = '0;
            mdl_cnt = 0;
            for (int i = 0; i < N; i++) acc[i] = 0;
        end else begin
            if (mac_sof) begin
                mdl_cnt = 0;
                since = 0;
                mdl_valid = '0;
                mdl_maxd = 0;
                for (int i = 0; i < N; i++) begin
                    delay[i] = $urandom_range(0, 4);
                    if (delay[i] > mdl_maxd) mdl_maxd = delay[i];
                end
            end
            if (mac_sof || (mdl_cnt > 0 && mdl_cnt < N)) begin
                sb = mac_B;
                for (int i = 0; i < N; i++) begin
                    sa = mac_A[i*WIDTH +: WIDTH];
                    acc[i] = (mac_sof ? 64'sd0 : acc[i]) + longint'(sa) * longint'(sb);
                end
                mdl_cnt++;
            end
            if (mdl_cnt == N) begin
                for (int i = 0; i < N; i++) if (since >= delay[i]) mdl_valid[i] = 1'b1;
                since++;
            end
        end
    end

    always_comb begin
        mac_C = '0;
        for (int i = 0; i < N; i++) mac_C[i*M_WIDTH +: M_WIDTH] = acc[i][M_WIDTH-1:0];
    end
    assign mac_valid = force_invalid ? '0 : mdl_valid;

    function automatic logic [N*M_WIDTH-1:0] ref_result();
        logic [N*M_WIDTH-1:0] r;
        logic signed [WIDTH-1:0] a, b;
        logic [63:0] t;
        longint s;
        r = '0;
        for (int i = 0; i < N; i++) begin
            s = 0;
            for (int k = 0; k < N; k++) begin
                a = ref_a[i][k];
                b = ref_b[k];
                s += longint'(a) * longint'(b);
            end
            t = s;
            r[i*M_WIDTH +: M_WIDTH] = t[M_WIDTH-1:0];
        end
        return r;
    endfunction

    // driver tasks (called at a negedge, return at a negedge)
    task automatic write_raw(input logic sel, input int row, input int col, input logic [WIDTH-1:0] d);
        wr_en = 1'b1; wr_sel = sel; wr_row = IDX_W'(row); wr_col = IDX_W'(col); wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic load_a(input int r, input int c, input logic [WIDTH-1:0] d);
        write_raw(1'b0, r, c, d);
        ref_a[r][c] = d;
    endtask

    task automatic load_b(input int c, input logic [WIDTH-1:0] d);
        write_raw(1'b1, $urandom_range(0, 7), c, d);
        ref_b[c] = d;
    endtask

    task automatic load_random();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) load_a(r, c, WIDTH'($urandom_range(0, 65535)));
        for (int c = 0; c < N; c++) load_b(c, WIDTH'($urandom_range(0, 65535)));
    endtask

    task automatic clear_ref();
        for (int r = 0; r < N; r++) begin
            ref_b[r] = '0;
            for (int c = 0; c < N; c++) ref_a[r][c] = '0;
        end
    endtask

    // one frame with start pulsed; optional dropped write of A[0][0]=7 at cycle wr_at
    task automatic run_frame(input string tag, input int wr_at);
        int cyc, sof_cyc, sof_n, done_cyc, bad, exp_done, k;
        logic [N*M_WIDTH-1:0] exp;
        exp_q.push_back(ref_result());
        start = 1'b1;
        cyc = 0; sof_cyc = -1; sof_n = 0; done_cyc = -1; bad = 0; exp_done = -1;
        while (cyc < 300 && done_cyc < 0) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                start = 1'b0;
                wr_en = 1'b0;
                n_vec++;
                if (busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL %s busy_after_start: got %b want 1", tag, busy);
                end
            end
            if (cyc == wr_at) begin
                wr_en = 1'b1; wr_sel = 1'b0; wr_row = '0; wr_col = '0; wr_data = 16'd7;
            end else if (cyc == wr_at + 1) begin
                wr_en = 1'b0;
            end
            if (mac_sof === 1'b1) begin
                sof_n++;
                if (sof_cyc < 0) sof_cyc = cyc;
            end
            if (sof_cyc > 0 && cyc - sof_cyc < N) begin
                k = cyc - sof_cyc;
                for (int i = 0; i < N; i++) if (mac_A[i*WIDTH +: WIDTH] !== ref_a[i][k]) bad++;
                if (mac_B !== ref_b[k]) bad++;
                if (k == N - 1) exp_done = cyc + 1 + mdl_maxd;
            end
            if (done === 1'b1) done_cyc = cyc;
        end
        exp = exp_q.pop_front();
        n_vec++;
        if (done_cyc < 0) begin
            n_err++;
            $display("FAIL %s done_timeout: no done within %0d cycles", tag, cyc);
        end
        n_vec++;
        if (sof_cyc !== 2) begin n_err++; $display("FAIL %s sof_latency: got %0d want 2", tag, sof_cyc); end
        n_vec++;
        if (sof_n !== 1) begin n_err++; $display("FAIL %s sof_count: got %0d want 1", tag, sof_n); end
        n_vec++;
        if (bad !== 0) begin n_err++; $display("FAIL %s beat_data: %0d bad lanes want 0", tag, bad); end
        n_vec++;
        if (done_cyc !== exp_done) begin n_err++; $display("FAIL %s done_cycle: got %0d want %0d", tag, done_cyc, exp_done); end
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL %s busy_at_done: got %b want 0", tag, busy); end
        n_vec++;
        if (res_data !== exp) begin n_err++; $display("FAIL %s res_data: got %h want %h", tag, res_data, exp); end
        n_vec++;
        if (err !== exp_err) begin n_err++; $display("FAIL %s err: got %b want %b", tag, err, exp_err); end
        @(negedge clk);
        n_vec++;
        if (done !== 1'b0) begin n_err++; $display("FAIL %s done_pulse_width: got %b want 0", tag, done); end
    endtask

    task automatic check_all_zero(input string tag);
        n_vec++;
        if ({busy, done, mac_sof, err} !== 4'b0 || mac_A !== '0 || mac_B !== '0 || res_data !== '0) begin
            n_err++;
            $display("FAIL %s outputs_zero: busy=%b done=%b sof=%b err=%b A=%h B=%h res=%h want all 0",
                     tag, busy, done, mac_sof, err, mac_A, mac_B, res_data);
        end
        n_vec++;
        if (dbg_state !== S_IDLE) begin n_err++; $display("FAIL %s state_idle: got %0d want 0", tag, dbg_state); end
    endtask

    task automatic test_reset();
        clear_ref();
        rst_n = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("post_reset");
    endtask

    task automatic test_identity();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) load_a(r, c, (r == c) ? 16'd1 : 16'd0);
        for (int c = 0; c < N; c++) load_b(c, WIDTH'(c + 1));
        run_frame("identity", -1);
    endtask

    task automatic test_signed();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) load_a(r, c, 16'hFFFF);
        for (int c = 0; c < N; c++) load_b(c, WIDTH'(100 * (c + 1)));
        run_frame("signed", -1);
    endtask

    task automatic test_write_while_busy();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) load_a(r, c, (r == c) ? 16'd1 : 16'd0);
        run_frame("busy_write_f1", 3);
        run_frame("busy_write_f2", -1);
    endtask

    task automatic test_write_with_start();
        logic [WIDTH-1:0] d;
        d = WIDTH'($urandom_range(1, 65535));
        wr_en = 1'b1; wr_sel = 1'b0; wr_row = 3'd2; wr_col = 3'd3; wr_data = d;
        ref_a[2][3] = d;
        run_frame("write_with_start", -1);
    endtask

    task automatic test_write_bounds();
        logic [WIDTH-1:0] d;
        load_random();
        for (int r = N; r < 8; r++) write_raw(1'b0, r, $urandom_range(0, N - 1), 16'h5A5A);
        write_raw(1'b0, 1, 6, 16'h1234);
        write_raw(1'b1, 0, 7, 16'h4321);
        d = WIDTH'($urandom_range(0, 65535));
        write_raw(1'b1, 7, 2, d);
        ref_b[2] = d;
        run_frame("write_bounds", -1);
    endtask

    task automatic test_random();
        for (int f = 0; f < 3; f++) begin
            load_random();
            if (f == 2) begin
                load_a(4, 0, 16'h8000);
                load_b(0, 16'h8000);
            end
            run_frame($sformatf("random_%0d", f), -1);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, dn, sn, k;
        int sof_c [2];
        int done_c [2];
        int exp_d [2];
        logic [N*M_WIDTH-1:0] exp;
        load_random();
        exp_q.push_back(ref_result());
        exp_q.push_back(ref_result());
        start = 1'b1;
        cyc = 0; dn = 0; sn = 0;
        sof_c[0] = -1; sof_c[1] = -1; done_c[0] = -1; done_c[1] = -1; exp_d[0] = -2; exp_d[1] = -2;
        while (cyc < 400 && dn < 2) begin
            @(negedge clk);
            cyc++;
            if (dn == 1 && busy === 1'b1) start = 1'b0;
            if (mac_sof === 1'b1) begin
                if (sn < 2) sof_c[sn] = cyc;
                sn++;
            end
            if (sn > 0 && sn <= 2) begin
                k = cyc - sof_c[sn-1];
                if (k == N - 1) exp_d[sn-1] = cyc + 1 + mdl_maxd;
            end
            if (done === 1'b1) begin
                exp = exp_q.pop_front();
                n_vec++;
                if (res_data !== exp) begin
                    n_err++;
                    $display("FAIL b2b_res_%0d: got %h want %h", dn, res_data, exp);
                end
                done_c[dn] = cyc;
                dn++;
            end
        end
        start = 1'b0;
        n_vec++;
        if (dn !== 2) begin n_err++; $display("FAIL b2b_done_count: got %0d want 2", dn); end
        n_vec++;
        if (sn !== 2) begin n_err++; $display("FAIL b2b_sof_count: got %0d want 2", sn); end
        n_vec++;
        if (sof_c[1] !== done_c[0] + 2) begin
            n_err++; $display("FAIL b2b_restart: sof2 at %0d want %0d", sof_c[1], done_c[0] + 2);
        end
        for (int j = 0; j < 2; j++) begin
            n_vec++;
            if (done_c[j] !== exp_d[j]) begin
                n_err++; $display("FAIL b2b_done_cycle_%0d: got %0d want %0d", j, done_c[j], exp_d[j]);
            end
        end
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic test_reset_mid_stream();
        int cyc, dn;
        load_random();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (cyc < 20 && mac_sof !== 1'b1) begin @(negedge clk); cyc++; end
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid_stream");
        clear_ref();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        repeat (20) begin @(negedge clk); if (done === 1'b1) dn++; end
        n_vec++;
        if (dn !== 0) begin n_err++; $display("FAIL reset_no_done: got %0d dones want 0", dn); end
        run_frame("after_reset_cleared", -1);
        load_random();
        run_frame("after_reset_fresh", -1);
    endtask

    task automatic test_timeout();
        int cyc, err_cyc, dn;
        logic [N*M_WIDTH-1:0] prev;
        load_random();
        prev = res_data;
        force_invalid = 1'b1;
        start = 1'b1;
        cyc = 0; err_cyc = -1; dn = 0;
`ifdef MAC_VEC_SEQ_TIMEOUT_EN
        while (cyc < 200 && err_cyc < 0) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) start = 1'b0;
            if (done === 1'b1) dn++;
            if (err === 1'b1) err_cyc = cyc;
        end
        n_vec++;
        if (err_cyc !== N + 1 + TIMEOUT) begin
            n_err++; $display("FAIL timeout_err_cycle: got %0d want %0d", err_cyc, N + 1 + TIMEOUT);
        end
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL timeout_busy: got %b want 0", busy); end
        n_vec++;
        if (dn !== 0) begin n_err++; $display("FAIL timeout_no_done: got %0d want 0", dn); end
        n_vec++;
        if (res_data !== prev) begin n_err++; $display("FAIL timeout_res_held: got %h want %h", res_data, prev); end
        force_invalid = 1'b0;
        exp_err = 1'b1;
        run_frame("after_timeout", -1);
`else
        while (cyc < 150) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) start = 1'b0;
            if (done === 1'b1) dn++;
            if (err !== 1'b0) err_cyc = cyc;
        end
        n_vec++;
        if (busy !== 1'b1 || dn !== 0) begin
            n_err++; $display("FAIL wait_forever: busy=%b dones=%0d want busy 1 dones 0", busy, dn);
        end
        n_vec++;
        if (err_cyc !== -1) begin n_err++; $display("FAIL err_tied_low: err seen at %0d want never", err_cyc); end
        exp_q.push_back(ref_result());
        force_invalid = 1'b0;
        cyc = 0;
        while (cyc < 20 && done !== 1'b1) begin @(negedge clk); cyc++; end
        n_vec++;
        if (done !== 1'b1) begin n_err++; $display("FAIL wait_release_done: got %b want 1", done); end
        n_vec++;
        if (res_data !== exp_q[0]) begin n_err++; $display("FAIL wait_release_res: got %h want %h", res_data, exp_q[0]); end
        exp_q.delete();
        @(negedge clk);
        n_vec++;
        if (res_data === prev) begin n_err++; $display("FAIL wait_release_update: res_data still %h", prev); end
`endif
    endtask

    initial begin
        test_reset();
        test_identity();
        test_signed();
        test_write_while_busy();
        test_write_with_start();
        test_write_bounds();
        test_random();
        test_back_to_back();
        test_reset_mid_stream();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
